// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline latches and PC.
// Define HAZARD_PERF_CNT_EN to build the stall and squash counters.
module pipeline_hazard_ctrl #(
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_dREN,
    input  logic [REGADDR_W-1:0] ex_wsel,
    input  logic                 ex_redirect,
    input  logic                 mem_dREN,
    input  logic                 mem_dWEN,
    input  logic                 wb_halt,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALT
    } state_t;

    state_t state_q, state_d;
    logic   memwait;
    logic   loaduse;

    assign memwait = (mem_dREN | mem_dWEN) & ~dhit;
    assign loaduse = ex_dREN & (ex_wsel != '0) &
                     ((ex_wsel == id_rs) |
                      (id_uses_rt & (ex_wsel == id_rt)));

    always_comb begin
        state_d     = RUN;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == HALT) begin
            state_d  = HALT;
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (wb_halt) begin
            state_d  = HALT;
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (memwait) begin
            state_d  = DWAIT;
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_redirect) begin
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loaduse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALT);

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             redir_cyc;

    assign redir_cyc = (state_q != HALT) & ~wb_halt & ~memwait & ex_redirect;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (state_q != HALT) begin
            if (!pc_en && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + CNT_ONE;
            end
            if (redir_cyc && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
